fp32_div_seq: RTL and testbench
===============================

# fp32_div_seq

Iterative single-precision divider operating on the 34-bit floating-point encoding used by `fp32_mul`: `[33:32]` exception, `[31]` sign, `[30:23]` exponent, `[22:0]` fraction. It is the inverse-operation companion to the combinational multiplier. It accepts one operand pair via a valid/ready handshake and computes R = X / Y with a restoring radix-2 mantissa divider, one quotient bit per cycle. The rounded result is presented on a held valid/ready output port. It serves datapaths that need division but cannot afford a combinational array divider.

## Interface
- No parameters. Width, format and latency are fixed.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  divider idle, can accept; reset value 1.
- `X`  in  34  dividend.
- `Y`  in  34  divisor.
- `out_valid`  out  1  R valid; reset value 0.
- `out_ready`  in  1  consumer accepts R.
- `R`  out  34  quotient; reset value 0.

## Operation
- Exception codes:
  - 00 zero.
  - 01 normal, value (-1)^s · 1.f · 2^(e-127), all e in 0..255 legal.
  - 10 infinity.
  - 11 NaN.
  - No subnormals.
- FSM states: IDLE, DIV, ROUND, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, register X, Y and go to DIV with bit counter = 25.
  - DIV: 26 cycles. Each cycle: trial = rem − {1,fy}. If trial ≥ 0, rem = trial and q bit = 1; else q bit = 0. Then rem <<= 1. Initial rem = {1,fx}. Produces Q[25:0], with Q[25] the integer bit.
  - ROUND: normalize, round, classify, and load R. Go to DONE.
  - DONE: `out_valid`=1 and R held. On `out_ready`, go to IDLE.
- Normalize:
  - If Q[25]=1: frac = Q[24:2], guard = Q[1], sticky = Q[0] | (rem≠0), e = ex − ey + 127.
  - If Q[25]=0: frac = Q[23:1], guard = Q[0], sticky = (rem≠0), e = ex − ey + 126.
  - Compute e in signed 10 bits.
- Rounding is round-to-nearest-even: increment when guard & (sticky | frac[0]). A fraction carry-out sets frac = 0 and e += 1.
- Range check after rounding:
  - e > 255: infinity.
  - e < 0: zero, flush; no subnormals.
- Sign is always sx ^ sy, except NaN.
- Special cases are resolved in ROUND and still take the full latency:
  - NaN if either operand is NaN, 0/0, or inf/inf.
  - Infinity if X is inf and Y is not inf/NaN, or X is normal and Y is zero.
  - Zero if X is zero and Y is normal/inf, or X is normal and Y is inf.
- Output encodings:
  - NaN: R = 34'h300000000.
  - Zero/inf: bits [30:0] = 0, sign = sx ^ sy.
- No pipelining. A new operand is accepted only in IDLE. `in_valid` in any other state is ignored and not queued.

## Timing
- Accept edge A: `in_valid` & `in_ready` sampled at A. `in_ready` is low from A until the return to IDLE.
- DIV edges A+1..A+26, ROUND edge A+27. `out_valid` and R are valid after edge A+27.
- `out_valid` and R are held stable until `out_ready` is sampled high at edge B. After B: `out_valid`=0 and `in_ready`=1. Earliest next accept is edge B+1.
- Minimum initiation interval is 29 cycles when `out_ready` is held high.
- `out_ready` high while `out_valid`=0 has no effect.
- Reset asserted at any point aborts immediately. State goes to IDLE, `out_valid`=0, `in_ready`=1, R=0. Partial results are discarded.
- X and Y may change after the accept edge without affecting the result.

## Test plan
- Basic: 13fc00000 / 13f000000 -> 140400000 (1.5/0.5=3.0). 1c0a00000 / 1c0000000 -> 140200000 (−5/−2=2.5). `out_valid` rises exactly 27 cycles after accept.
- Rounding: 13f800000 / 140400000 -> 13eaaaaab (1/3, round up). 13f800000 / 13f800000 -> 13f800000 (exact, Q[25]=1, rem=0).
- Specials:
  - 13f800000 / 000000000 -> 200000000.
  - 000000000 / 000000000 -> 300000000.
  - 1bf800000 / 200000000 -> 080000000 (−1/+inf = −0).
  - 300000000 / 13f800000 -> 300000000.
  - Each with full latency.
- Range:
  - 17f000000 / 100800000 -> 200000000 (overflow to inf).
  - 100800000 / 17f000000 -> 000000000 (underflow to zero).
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`. R stays constant, `in_ready`=0, and a new `in_valid` is ignored. After `out_ready` pulses, the next operand is accepted at edge B+1 and produces the correct result.
- Reset: assert `rst_n`=0 at DIV cycle 12. `out_valid`=0, `in_ready`=1, R=0 immediately. After release, 140400000 / 13f000000 -> 140c00000 (3/0.5=6) with normal latency.

Source files
------------

// File: rtl/fp32_div_seq_if.sv
// Operand/result handshake bundle for the sequential fp32 divider.
// Master drives operands and out_ready; slave is the divider.
interface fp32_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] X;
  logic [33:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] R;

  modport master (
    output in_valid, X, Y, out_ready,
    input  in_ready, out_valid, R
  );

  modport slave (
    input  in_valid, X, Y, out_ready,
    output in_ready, out_valid, R
  );
endinterface

// File: rtl/fp32_div_seq.sv
// Iterative fp32 divider, 34-bit exception-tagged format.
// Restoring radix-2 mantissa division, one quotient bit per cycle.
module fp32_div_seq (
  input  logic           clk,
  input  logic           rst_n,
  fp32_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } state_t;

  state_t      st;
  logic [4:0]  cnt;
  logic [24:0] rem;
  logic [25:0] q;
  logic [10:0] xh;
  logic [33:0] yr;

  logic [25:0] t;
  logic [24:0] rem_n;

  always_comb begin
    t     = {1'b0, rem} - {2'b00, 1'b1, yr[22:0]};
    rem_n = t[25] ? rem : t[24:0];
  end

  logic [1:0]        xe;
  logic [1:0]        ye;
  logic              nan;
  logic              inf;
  logic              zro;
  logic              s;
  logic signed [9:0] eb;
  logic signed [9:0] er;
  logic [22:0]       frac;
  logic [22:0]       fr;
  logic              g;
  logic              sk;
  logic              inc;
  logic              cy;
  logic [33:0]       res;

  always_comb begin
    xe  = xh[10:9];
    ye  = yr[33:32];
    nan = (xe == 2'b11) || (ye == 2'b11) ||
          (xe == 2'b00 && ye == 2'b00) ||
          (xe == 2'b10 && ye == 2'b10);
    inf = (xe == 2'b10) || (xe == 2'b01 && ye == 2'b00);
    zro = (xe == 2'b00) || (xe == 2'b01 && ye == 2'b10);
    s   = xh[8] ^ yr[31];
    eb  = $signed({2'b00, xh[7:0]}) -
          $signed({2'b00, yr[30:23]});
    if (q[25]) begin
      frac = q[24:2];
      g    = q[1];
      sk   = q[0] | (|rem);
      eb   = eb + 10'sd127;
    end else begin
      frac = q[23:1];
      g    = q[0];
      sk   = |rem;
      eb   = eb + 10'sd126;
    end
    inc       = g & (sk | frac[0]);
    {cy, fr}  = {1'b0, frac} + {23'd0, inc};
    // A carry out wraps fr to zero; only the exponent moves.
    er        = eb + $signed({9'd0, cy});
    if (nan)
      res = 34'h300000000;
    else if (inf)
      res = {2'b10, s, 31'd0};
    else if (zro)
      res = {2'b00, s, 31'd0};
    else if (er > 10'sd255)
      res = {2'b10, s, 31'd0};
    else if (er < 10'sd0)
      res = {2'b00, s, 31'd0};
    else
      res = {2'b01, s, er[7:0], fr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      cnt           <= '0;
      rem           <= '0;
      q             <= '0;
      xh            <= '0;
      yr            <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.R         <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.in_valid) begin
            xh           <= bus.X[33:23];
            yr           <= bus.Y;
            rem          <= {2'b01, bus.X[22:0]};
            q            <= '0;
            cnt          <= 5'd25;
            bus.in_ready <= 1'b0;
            st           <= DIV;
          end
        end
        DIV: begin
          rem <= rem_n << 1;
          q   <= {q[24:0], ~t[25]};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0)
            st <= ROUND;
        end
        ROUND: begin
          bus.R         <= res;
          bus.out_valid <= 1'b1;
          st            <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            st            <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Bench for fp32_div_seq: directed vectors, rational-arithmetic
// reference model, and a per-cycle result/latency monitor.
module tb_fp32_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp32_div_seq_if bus();

  fp32_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int mchecks = 0;
  int merrors = 0;
  int cyc = 0;
  int acc_edge = 0;
  bit vprev = 1'b0;
  logic [33:0] expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact rational quotient of the mantissas, rounded by
  // comparing the exact remainder against half an ulp.
  function automatic logic [33:0] model(input logic [33:0] x,
                                        input logic [33:0] y);
    logic   s;
    logic [1:0] xe, ye;
    longint mx, my, num, mant, r;
    int     e;
    logic [63:0] mv;
    logic [7:0]  e8;
    xe = x[33:32];
    ye = y[33:32];
    s  = x[31] ^ y[31];
    if (xe == 3 || ye == 3 || (xe == 0 && ye == 0) ||
        (xe == 2 && ye == 2))
      return 34'h300000000;
    if (xe == 2 || ye == 0)
      return {2'b10, s, 31'd0};
    if (xe == 0 || ye == 2)
      return {2'b00, s, 31'd0};
    mx = longint'({1'b1, x[22:0]});
    my = longint'({1'b1, y[22:0]});
    e  = int'(x[30:23]) - int'(y[30:23]);
    if (mx >= my) begin
      num = mx << 23;
      e   = e + 127;
    end else begin
      num = mx << 24;
      e   = e + 126;
    end
    mant = num / my;
    r    = num % my;
    if (2 * r > my || (2 * r == my && mant % 2 == 1))
      mant = mant + 1;
    if (mant == (longint'(1) << 24)) begin
      mant = longint'(1) << 23;
      e    = e + 1;
    end
    if (e > 255)
      return {2'b10, s, 31'd0};
    if (e < 0)
      return {2'b00, s, 31'd0};
    mv = 64'(mant);
    e8 = 8'(e);
    return {2'b01, s, e8, mv[22:0]};
  endfunction

  task automatic chk(input string nm, input logic [33:0] act,
                     input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      vprev = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(bus.X, bus.Y));
        acc_edge = cyc + 1;
      end
      if (bus.out_valid) begin
        if (!vprev) begin
          mchecks++;
          if (cyc - acc_edge != 27) begin
            merrors++;
            $display("FAIL latency: got %0d expected 27",
                     cyc - acc_edge);
          end
        end
        mchecks++;
        if (expq.size() == 0) begin
          merrors++;
          $display("FAIL r_model: got %h with nothing pending",
                   bus.R);
        end else if (bus.R !== expq[0]) begin
          merrors++;
          $display("FAIL r_model: got %h expected %h",
                   bus.R, expq[0]);
        end
        mchecks++;
        if (bus.in_ready !== 1'b0) begin
          merrors++;
          $display("FAIL in_ready_busy: got %b expected 0",
                   bus.in_ready);
        end
        if (bus.out_ready && expq.size() != 0)
          void'(expq.pop_front());
      end
      vprev = bus.out_valid;
    end
  end

  task automatic wait_out(input string nm, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got no out_valid expected 1", nm);
    end
  endtask

  // Called just after a rising edge with the divider idle.
  task automatic do_op(input logic [33:0] x, input logic [33:0] y,
                       input logic [33:0] lit, input bit uselit,
                       input string nm);
    bit got;
    if (uselit) chk({nm, "_model"}, model(x, y), lit);
    bus.in_valid  = 1'b1;
    bus.X         = x;
    bus.Y         = y;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.X        = {2'b11, 32'($urandom)};
    bus.Y        = {2'b01, 32'($urandom)};
    wait_out(nm, got);
    if (got && uselit) chk(nm, bus.R, lit);
    @(posedge clk); #1;
  endtask

  initial begin
    bit          got;
    logic [33:0] r0;
    logic [33:0] rx, ry;
    bus.in_valid  = 1'b0;
    bus.X         = '0;
    bus.Y         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {33'd0, bus.out_valid}, 34'd0);
    chk("rst_in_ready", {33'd0, bus.in_ready}, 34'd1);
    chk("rst_r", bus.R, 34'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(34'h13fc00000, 34'h13f000000, 34'h140400000, 1, "div_3");
    do_op(34'h1c0a00000, 34'h1c0000000, 34'h140200000, 1, "div_2p5");
    do_op(34'h13f800000, 34'h140400000, 34'h13eaaaaab, 1, "third");
    do_op(34'h13f800000, 34'h13f800000, 34'h13f800000, 1, "one");
    do_op(34'h13f800000, 34'h000000000, 34'h200000000, 1, "x_by_0");
    do_op(34'h000000000, 34'h000000000, 34'h300000000, 1, "zero_0");
    do_op(34'h1bf800000, 34'h200000000, 34'h080000000, 1, "by_inf");
    do_op(34'h300000000, 34'h13f800000, 34'h300000000, 1, "nan_in");
    do_op(34'h200000000, 34'h200000000, 34'h300000000, 1, "inf_inf");
    do_op(34'h17f000000, 34'h100800000, 34'h200000000, 1, "ovf");
    do_op(34'h100800000, 34'h17f000000, 34'h000000000, 1, "unf");

    // Backpressure with a blocked request waiting behind it.
    bus.in_valid  = 1'b1;
    bus.X         = 34'h13f800000;
    bus.Y         = 34'h140400000;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out("bp_first", got);
    r0 = bus.R;
    chk("bp_first", r0, 34'h13eaaaaab);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.X        = 34'h140400000;
      bus.Y        = 34'h13f000000;
      @(negedge clk);
      chk("bp_hold_r", bus.R, r0);
      chk("bp_hold_in_ready", {33'd0, bus.in_ready}, 34'd0);
      chk("bp_hold_out_valid", {33'd0, bus.out_valid}, 34'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_after_b_valid", {33'd0, bus.out_valid}, 34'd0);
    chk("bp_after_b_ready", {33'd0, bus.in_ready}, 34'd1);
    @(posedge clk); #1;
    chk("bp_accept_b1", {33'd0, bus.in_ready}, 34'd0);
    bus.in_valid = 1'b0;
    wait_out("bp_second", got);
    if (got) chk("bp_second", bus.R, 34'h140c00000);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of DIV.
    bus.in_valid = 1'b1;
    bus.X        = 34'h140400000;
    bus.Y        = 34'h13f000000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {33'd0, bus.out_valid}, 34'd0);
    chk("mid_rst_in_ready", {33'd0, bus.in_ready}, 34'd1);
    chk("mid_rst_r", bus.R, 34'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(34'h140400000, 34'h13f000000, 34'h140c00000, 1, "post_rst");

    for (int i = 0; i < 12; i++) begin
      rx = {2'b01, 1'($urandom), 8'($urandom_range(100, 150)),
            23'($urandom)};
      ry = {2'b01, 1'($urandom), 8'($urandom_range(100, 150)),
            23'($urandom)};
      do_op(rx, ry, 34'd0, 0, "rand_norm");
    end
    for (int i = 0; i < 12; i++) begin
      rx = {2'($urandom_range(0, 3)), 32'($urandom)};
      ry = {2'($urandom_range(0, 3)), 32'($urandom)};
      do_op(rx, ry, 34'd0, 0, "rand_any");
    end

    repeat (2) @(posedge clk);
    checks = checks + mchecks;
    errors = errors + merrors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
